// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU: datapath width, function codes
// and the controller state encoding.
package alu_pkg;

  localparam int N_DEF = 32;

  localparam logic [2:0] FN_AND  = 3'b000;
  localparam logic [2:0] FN_OR   = 3'b001;
  localparam logic [2:0] FN_ADD  = 3'b010;
  localparam logic [2:0] FN_ZERO = 3'b011;
  localparam logic [2:0] FN_ANDN = 3'b100;
  localparam logic [2:0] FN_ORN  = 3'b101;
  localparam logic [2:0] FN_SUB  = 3'b110;
  localparam logic [2:0] FN_SLTN = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// The team's combinational N-bit ALU. Carry-out is the adder carry and is
// only meaningful for FN_ADD.
module alu
  import alu_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_f,
  output logic [N-1:0] o_result,
  output logic         o_cout
);

  logic [N:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign o_cout = w_sum[N];

  always_comb begin
    o_result = '0;
    case (i_f)
      FN_AND:  o_result = i_a & i_b;
      FN_OR:   o_result = i_a | i_b;
      FN_ADD:  o_result = w_sum[N-1:0];
      FN_ZERO: o_result = '0;
      FN_ANDN: o_result = i_a & ~i_b;
      FN_ORN:  o_result = i_a | ~i_b;
      FN_SUB:  o_result = i_a - i_b;
      FN_SLTN: o_result = (i_a > i_b) ? '0 : N'(1);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the requester
// that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  always_comb begin
    o_grant_valid = |i_valid;
    o_grant_id    = 1'b0;
    case (i_valid)
      2'b01:   o_grant_id = 1'b0;
      2'b10:   o_grant_id = 1'b1;
      2'b11:   o_grant_id = ~i_last_grant;
      default: o_grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two valid/ready requesters: IDLE accepts one
// op, EXEC registers the ALU output, RESP holds the response until taken.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [2:0]       req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [2:0]       req1_f,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [N-1:0]     rsp0_result,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [N-1:0]     rsp1_result,
  output logic             rsp1_cout,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on anything but state, valids and history.
  state_t           r_state;
  logic             r_owner;
  logic             r_last_grant;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [2:0]       r_f;
  logic [N-1:0]     r_result;
  logic             r_cout;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;

  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_take;
  logic             w_rsp_taken;
  logic [N-1:0]     w_alu_result;
  logic             w_alu_cout;

  rr_arb2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant_valid(w_gnt_valid),
    .o_grant_id   (w_gnt_id)
  );

  alu #(.N(N)) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_f     (r_f),
    .o_result(w_alu_result),
    .o_cout  (w_alu_cout)
  );

  assign w_take      = (r_state == IDLE) && w_gnt_valid;
  assign w_rsp_taken = r_owner ? rsp1_ready : rsp0_ready;

  // Readies are masked by rst so every output reads 0 while reset is held.
  assign req0_ready  = ~rst & w_take & ~w_gnt_id;
  assign req1_ready  = ~rst & w_take & w_gnt_id;

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_cout   = r_cout;
  assign rsp1_cout   = r_cout;
  assign busy        = r_busy;
  assign op_count    = r_op_count;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_f          <= '0;
      r_result     <= '0;
      r_cout       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_a          <= w_gnt_id ? req1_a : req0_a;
            r_b          <= w_gnt_id ? req1_b : req0_b;
            r_f          <= w_gnt_id ? req1_f : req0_f;
            r_owner      <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_busy       <= 1'b1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          // The ALU leaves carry undefined except for ADD, so mask it here.
          r_result     <= w_alu_result;
          r_cout       <= (r_f == FN_ADD) && w_alu_cout;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_taken) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
            if (r_op_count != '1) begin
              r_op_count <= r_op_count + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
